// File: rtl/timer_pkg.sv
// Shared register-map constants and helpers for the timer bank.
// Register offsets and CTRL/STAT bit positions are identical for every channel.
package timer_pkg;

  localparam logic [2:0] OFF_CNT0 = 3'd0;
  localparam logic [2:0] OFF_CNT1 = 3'd1;
  localparam logic [2:0] OFF_CNT2 = 3'd2;
  localparam logic [2:0] OFF_CNT3 = 3'd3;
  localparam logic [2:0] OFF_CTRL = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_PRE  = 3'd6;

  localparam int B_EN   = 0;
  localparam int B_AUTO = 1;
  localparam int B_IE   = 2;
  localparam int B_LOAD = 7;
  localparam int B_SHOT = 7;

  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;

  // Little-endian byte pick from a value zero-extended to 32 bits.
  function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] idx);
    return v[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One down-counting timer channel: COUNT/RELOAD/SNAP, CTRL, sticky SHOT.
// The per-channel prescaler exists only when TIMER_PRESCALE_EN is defined.
module timer_chan
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic       rd0_i,
  input  logic [2:0] off_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       irq_req_o
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             shot_q, shot_d;
  logic [7:0]       pre_s;

  logic ctrl_wr_s, stat_wr_s, load_s, kill_s, tick_s, tick_eff_s, term_s;
  logic [31:0] cnt_ext_s, snap_ext_s;

  assign ctrl_wr_s  = wr_i & (off_i == OFF_CTRL);
  assign stat_wr_s  = wr_i & (off_i == OFF_STAT);
  assign load_s     = ctrl_wr_s & wdata_i[B_LOAD];
  // A CTRL write clearing EN suppresses this cycle's tick, including a terminal one.
  assign kill_s     = ctrl_wr_s & ~wdata_i[B_EN];
  assign tick_eff_s = tick_s & ~kill_s & ~load_s;
  assign term_s     = tick_eff_s & (count_q == '0);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] pre_q, pre_d, psc_q, psc_d;

  assign tick_s = ctrl_q.en & (psc_q == pre_q);
  assign pre_s  = pre_q;

  // Prescaler next state: counts 0..PRE, restarting on EN=0 or LOAD.
  always_comb begin
    pre_d = pre_q;
    psc_d = psc_q;
    if (wr_i && (off_i == OFF_PRE)) begin
      pre_d = wdata_i;
    end else begin
      pre_d = pre_q;
    end
    if (!ctrl_q.en || load_s) begin
      psc_d = 8'd0;
    end else if (psc_q == pre_q) begin
      psc_d = 8'd0;
    end else begin
      psc_d = psc_q + 8'd1;
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= 8'd0;
      psc_q <= 8'd0;
    end else begin
      pre_q <= pre_d;
      psc_q <= psc_d;
    end
  end
`else
  assign tick_s = ctrl_q.en;
  assign pre_s  = 8'd0;
`endif

  // Counter, reload, snapshot, control and status next state.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    snap_d   = snap_q;
    ctrl_d   = ctrl_q;
    shot_d   = shot_q;

    for (int b = 0; b < NB; b++) begin
      if (wr_i && (off_i == 3'(b))) begin
        reload_d[8*b +: 8] = wdata_i;
      end else begin
        reload_d[8*b +: 8] = reload_q[8*b +: 8];
      end
    end

    if (load_s) begin
      count_d = reload_q;
    end else if (tick_eff_s) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else if (ctrl_q.auto_rl) begin
        count_d = reload_q;
      end else begin
        count_d = '0;
      end
    end else begin
      count_d = count_q;
    end

    if (term_s && !ctrl_q.auto_rl) begin
      ctrl_d.en = 1'b0;
    end else begin
      ctrl_d.en = ctrl_q.en;
    end
    if (ctrl_wr_s) begin
      ctrl_d.en      = wdata_i[B_EN];
      ctrl_d.auto_rl = wdata_i[B_AUTO];
      ctrl_d.ie      = wdata_i[B_IE];
    end else begin
      ctrl_d.auto_rl = ctrl_q.auto_rl;
      ctrl_d.ie      = ctrl_q.ie;
    end

    // Set has priority over a same-cycle write-1-to-clear.
    if (term_s) begin
      shot_d = 1'b1;
    end else if (stat_wr_s && wdata_i[B_SHOT]) begin
      shot_d = 1'b0;
    end else begin
      shot_d = shot_q;
    end

    if (rd0_i) begin
      snap_d = count_q;
    end else begin
      snap_d = snap_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      reload_q <= '0;
      snap_q   <= '0;
      ctrl_q   <= '0;
      shot_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      snap_q   <= snap_d;
      ctrl_q   <= ctrl_d;
      shot_q   <= shot_d;
    end
  end

  assign cnt_ext_s  = 32'(count_q);
  assign snap_ext_s = 32'(snap_q);

  // Read mux: byte 0 is live, bytes 1..3 come from the snapshot taken at byte 0.
  always_comb begin
    rdata_o = 8'd0;
    case (off_i)
      OFF_CNT0: rdata_o = byte_sel(cnt_ext_s, 2'd0);
      OFF_CNT1, OFF_CNT2, OFF_CNT3: begin
        if (int'(off_i) < NB) begin
          rdata_o = byte_sel(snap_ext_s, off_i[1:0]);
        end else begin
          rdata_o = 8'd0;
        end
      end
      OFF_CTRL: rdata_o = {5'b00000, ctrl_q.ie, ctrl_q.auto_rl, ctrl_q.en};
      OFF_STAT: rdata_o = {shot_q, 6'b000000, ctrl_q.en};
      OFF_PRE:  rdata_o = pre_s;
      default:  rdata_o = 8'd0;
    endcase
  end

  assign irq_req_o = shot_q & ctrl_q.ie;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH timer channels on an 8-bit register bus with a combined irq.
// Optional per-channel prescaler: define TIMER_PRESCALE_EN.
module timer_bank
  import timer_pkg::*;
#(
  parameter  int NCH   = 2,
  parameter  int WIDTH = 16,
  localparam int AW    = 3 + $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    dbw,
  output logic [7:0]    dbr,
  output logic          irq
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0]  ch_s;
  logic [2:0]     off_s;
  logic [7:0]     rdata_s [NCH];
  logic [NCH-1:0] req_s;
  logic [7:0]     dbr_q, dbr_d;
  logic           irq_q, irq_d;

  assign off_s = addr[2:0];

  if (NCH > 1) begin : g_multi
    assign ch_s = addr[AW-1:3];
  end else begin : g_single
    assign ch_s = '0;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    timer_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .wr_i     (cs & we & (ch_s == CW'(gi))),
      .rd0_i    (cs & ~we & (ch_s == CW'(gi)) & (off_s == OFF_CNT0)),
      .off_i    (off_s),
      .wdata_i  (dbw),
      .rdata_o  (rdata_s[gi]),
      .irq_req_o(req_s[gi])
    );
  end

  // Read data and irq next state; dbr holds between reads.
  always_comb begin
    dbr_d = dbr_q;
    if (cs && !we) begin
      dbr_d = rdata_s[ch_s];
    end else begin
      dbr_d = dbr_q;
    end
    irq_d = |req_s;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbr_q <= 8'd0;
      irq_q <= 1'b0;
    end else begin
      dbr_q <= dbr_d;
      irq_q <= irq_d;
    end
  end

  assign dbr = dbr_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank (NCH=4, WIDTH=16): stimulus queues
// expected values, a negedge monitor pops and compares.
module tb_timer_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs  = 1'b0;
  logic          we  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    dbw = 8'd0;
  logic [7:0]    dbr;
  logic          irq;

  timer_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .cs  (cs),
    .we  (we),
    .addr(addr),
    .dbw (dbw),
    .dbr (dbr),
    .irq (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] val;
    bit         is_irq;
  } exp_t;

  exp_t rd_q[$];
  exp_t sm_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic rd_v     = 1'b0;
  logic sm_chk   = 1'b0;

  always @(posedge clk) rd_v <= cs & ~we;

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act;
    if (rd_v) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_underflow: got dbr=%02h with no expectation", dbr);
      end else begin
        e = rd_q.pop_front();
        if (dbr !== e.val) begin
          failures++;
          $display("FAIL %s: got %02h expected %02h", e.name, dbr, e.val);
        end
      end
    end
    if (sm_chk) begin
      checks++;
      if (sm_q.size() == 0) begin
        failures++;
        $display("FAIL sm_underflow: sample with no expectation");
      end else begin
        e = sm_q.pop_front();
        act = e.is_irq ? {7'd0, irq} : dbr;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got %02h expected %02h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic op(input bit c, input bit w, input int a, input logic [7:0] d);
    @(posedge clk);
    #1;
    cs     = c;
    we     = w;
    addr   = a[AW-1:0];
    dbw    = d;
    sm_chk = 1'b0;
  endtask

  task automatic wr(input int ch, input int off, input logic [7:0] d);
    op(1'b1, 1'b1, ch * 8 + off, d);
  endtask

  task automatic rd(input int ch, input int off, input logic [7:0] e, input string nm);
    rd_q.push_back('{nm, e, 1'b0});
    op(1'b1, 1'b0, ch * 8 + off, 8'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, 0, 8'd0);
  endtask

  task automatic sample(input bit is_irq, input logic [7:0] e, input string nm);
    op(1'b0, 1'b0, 0, 8'd0);
    sm_q.push_back('{nm, e, is_irq});
    sm_chk = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sample(1'b1, 8'h00, "reset_irq");
    sample(1'b0, 8'h00, "reset_dbr");

    // One-shot on ch0
    wr(0, 0, 8'h05);
    wr(0, 1, 8'h00);
    wr(0, 4, 8'h80);
    wr(0, 4, 8'h05);
    rd(0, 0, 8'h05, "oneshot_cnt5");
    rd(0, 0, 8'h04, "oneshot_cnt4");
    idle(8);
    rd(0, 5, 8'h80, "oneshot_stat");
    rd(0, 4, 8'h04, "oneshot_ctrl_en_off");
    rd(0, 0, 8'h00, "oneshot_cnt_hold0");
    sample(1'b1, 8'h01, "oneshot_irq");
    wr(0, 5, 8'h80);
    wr(0, 4, 8'h00);
    sample(1'b1, 8'h00, "w1c_irq_drop");

    // Auto-reload on ch0, W1C colliding with terminal tick
    wr(0, 0, 8'h03);
    wr(0, 4, 8'h80);
    wr(0, 4, 8'h03);
    idle(4);
    rd(0, 5, 8'h81, "auto_first_shot");
    wr(0, 5, 8'h80);
    rd(0, 5, 8'h01, "auto_cleared");
    wr(0, 5, 8'h80);
    rd(0, 5, 8'h81, "auto_set_wins");
    rd(0, 0, 8'h02, "auto_reloaded_cnt");
    wr(0, 4, 8'h00);
    wr(0, 5, 8'h80);

    // EN=0 write at terminal tick: no SHOT
    wr(0, 4, 8'h80);
    wr(0, 4, 8'h01);
    idle(3);
    wr(0, 4, 8'h00);
    rd(0, 5, 8'h00, "en_off_vs_term");
    rd(0, 0, 8'h00, "en_off_cnt");

    // LOAD while ticking: load wins
    wr(0, 4, 8'h80);
    wr(0, 4, 8'h01);
    idle(1);
    wr(0, 4, 8'h81);
    rd(0, 0, 8'h03, "load_vs_tick");
    wr(0, 4, 8'h00);

    // Atomic multi-byte read on ch1
    wr(1, 0, 8'h00);
    wr(1, 1, 8'h01);
    wr(1, 4, 8'h80);
    wr(1, 4, 8'h01);
    rd(1, 0, 8'h00, "atomic_b0");
    idle(1);
    rd(1, 1, 8'h01, "atomic_b1_snap");
    rd(1, 2, 8'h00, "byte2_absent");
    rd(1, 3, 8'h00, "byte3_absent");
    wr(1, 4, 8'h00);

    // Channel isolation: only ch2 runs
    rd(0, 0, 8'h02, "ch0_frozen");
    wr(2, 0, 8'h02);
    wr(2, 4, 8'h80);
    wr(2, 4, 8'h05);
    idle(6);
    sample(1'b1, 8'h01, "ch2_irq");
    rd(2, 5, 8'h80, "ch2_shot");
    rd(3, 0, 8'h00, "ch3_idle");
    rd(1, 0, 8'hFB, "ch1_frozen");
    wr(2, 4, 8'h00);
    idle(1);
    sample(1'b1, 8'h00, "ie_mask_irq");
    rd(2, 5, 8'h80, "ie_mask_shot_kept");

`ifdef TIMER_PRESCALE_EN
    wr(3, 6, 8'h55);
    rd(3, 6, 8'h55, "pre_readback");
    wr(3, 6, 8'h02);
    wr(3, 0, 8'h01);
    wr(3, 4, 8'h80);
    wr(3, 4, 8'h03);
    idle(5);
    rd(3, 5, 8'h01, "pre_before_shot");
    rd(3, 5, 8'h81, "pre_shot_6clk");
    wr(3, 4, 8'h00);
`else
    wr(3, 6, 8'h55);
    rd(3, 6, 8'h00, "off6_reads0");
`endif
    rd(3, 7, 8'h00, "off7_reads0");

    // Asynchronous reset mid-count
    wr(2, 4, 8'h87);
    idle(6);
    sample(1'b1, 8'h01, "pre_reset_irq");
    rd(2, 4, 8'h07, "pre_reset_ctrl");
    idle(1);
    @(posedge clk);
    #1;
    cs  = 1'b0;
    we  = 1'b0;
    rst = 1'b0;
    sm_q.push_back('{"async_reset_irq", 8'h00, 1'b1});
    sm_chk = 1'b1;
    sample(1'b0, 8'h00, "async_reset_dbr");
    @(posedge clk);
    #1;
    sm_chk = 1'b0;
    rst    = 1'b1;
    rd(2, 0, 8'h00, "post_reset_cnt");
    rd(2, 5, 8'h00, "post_reset_stat");
    rd(2, 4, 8'h00, "post_reset_ctrl");
    idle(3);
    rd(2, 0, 8'h00, "post_reset_no_tick");
    sample(1'b1, 8'h00, "post_reset_irq");

    idle(2);
    checks++;
    if (rd_q.size() != 0 || sm_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", rd_q.size(), sm_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
